debounce_fsm: RTL and testbench
===============================

DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 The block SHALL take parameter STABLE_CYCLES, default 1000000, meaning the number of clock cycles the synchronized input must hold a new level before the debounced output changes (10 ms at 100 MHz).
REQ-002 The block SHALL derive localparam CNT_W = $clog2(STABLE_CYCLES), the width of the stability counter.
REQ-003 The block SHALL support STABLE_CYCLES >= 2 only; smaller values are unsupported.
REQ-004 clk  input  1  the single clock; all registers update on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 sw  input  1  raw asynchronous switch or button level, bouncing.
REQ-007 db_level  output  1  registered debounced level; feeds the level input of the downstream dual edge detector.
REQ-008 db_tick  output  1  registered one-cycle pulse on every db_level change, either direction.

Function
REQ-009 sw SHALL pass through a 2-flop synchronizer (sync_q1 then sync_q2), and the FSM SHALL sample only sync_q2.
REQ-010 A value of sw sampled at edge j SHALL first be seen by the FSM at edge j+2.
REQ-011 The FSM SHALL have four states, ZERO, WAIT1, ONE and WAIT0, held in a registered state with separate next-state logic.
REQ-012 In ZERO, sync_q2=1 SHALL move the FSM to WAIT1 and clear cnt to 0; otherwise the FSM SHALL stay in ZERO.
REQ-013 In WAIT1, sync_q2=0 SHALL return the FSM to ZERO and clear cnt, rejecting the glitch.
REQ-014 In WAIT1, sync_q2=1 with cnt=STABLE_CYCLES-1 SHALL move the FSM to ONE.
REQ-015 In WAIT1, sync_q2=1 with cnt<STABLE_CYCLES-1 SHALL increment cnt and keep the FSM in WAIT1.
REQ-016 ONE and WAIT0 SHALL mirror ZERO and WAIT1 with the levels inverted: ONE->WAIT0 on sync_q2=0, WAIT0->ONE on sync_q2=1, WAIT0->ZERO on terminal count.
REQ-017 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL NOT wrap; it is cleared on every entry to WAIT1 or WAIT0.
REQ-018 db_level SHALL be 1 exactly while the state is ONE or WAIT0, registered with no combinational path from sw.
REQ-019 db_tick SHALL be 1 for exactly the one cycle following the edge on which the FSM enters ONE from WAIT1 or ZERO from WAIT0, and 0 otherwise.
REQ-020 Acceptance rule: a new level SHALL be accepted only when sw is sampled at that level on STABLE_CYCLES+1 consecutive rising edges.
REQ-021 A run of exactly STABLE_CYCLES samples SHALL be rejected.
REQ-022 Latency: for a clean sw step first sampled at edge k, db_level and db_tick SHALL change after edge k+2+STABLE_CYCLES.
REQ-023 The FSM SHALL produce no ticks while sw is stable.
REQ-024 Bounce during WAIT1 or WAIT0 SHALL restart qualification from the stable state, so only one db_tick occurs per accepted transition.
REQ-025 A toggle of sw on the same edge that cnt reaches terminal count SHALL be governed by the sync_q2 value sampled on that edge, per REQ-013 and REQ-014.

Reset
REQ-026 With rst_n=0 at a rising edge: state=ZERO, cnt=0, sync_q1=sync_q2=0, db_level=0, db_tick=0.
REQ-027 Reset SHALL have priority over all FSM transitions.
REQ-028 Reset asserted in any state, including mid-count in WAIT1 or WAIT0, SHALL abort the qualification, with no db_tick generated during or after reset.
REQ-029 After rst_n deasserts with sw held at 1, the FSM SHALL qualify the level normally: db_level rises STABLE_CYCLES+2 edges later with one db_tick.

Verification
REQ-030 The bench SHALL use STABLE_CYCLES=4 and 10 ns clk; all scenarios below apply at that setting.
REQ-031 Scenario, clean rise: sw 0->1 first sampled at edge k -> db_level=1 after edge k+6, db_tick high for one cycle, no further ticks.
REQ-032 Scenario, short glitch rejected: sw high for 4 sampled edges, then 0 -> db_level stays 0, db_tick never asserts.
REQ-033 Scenario, minimum pulse accepted: sw high for 5 sampled edges, then 0 -> db_level rises once, then falls 6 edges after sw returns low; exactly two ticks in total.
REQ-034 Scenario, bounce: sw toggles 1,0,1,1,0,1 every cycle, then holds 1 -> exactly one rise tick, timed from the final 0->1, per REQ-022.
REQ-035 Scenario, reset mid-qualification: sw held 1, rst_n=0 for one cycle while in WAIT1 with cnt=2 -> all outputs 0, then qualification restarts and db_level rises 6 edges after reset release.
REQ-036 Scenario, chaining: db_level connected to the dual edge detector level input -> each accepted rise or fall yields exactly one edg pulse.

Source files
------------

// File: rtl/debounce_fsm.sv
// Switch debouncer: two-flop synchronizer followed by a four-state
// qualification FSM. A new level is accepted only after the synchronized
// input has held it for STABLE_CYCLES+1 consecutive samples. db_level is
// the registered debounced level and db_tick pulses once per change.
module debounce_fsm #(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic             sync_q1;
    logic             sync_q2;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             tick_q;
    logic             tick_d;

    // Bring the raw asynchronous switch level into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sw;
            sync_q2 <= sync_q1;
        end
    end

    // Next-state, counter and output decode from the synchronized level only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (sync_q2) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!sync_q2) begin
                    // Glitch: fall back to the stable low level.
                    state_d = ZERO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ONE;
                    tick_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ONE: begin
                if (!sync_q2) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (sync_q2) begin
                    // Glitch: fall back to the stable high level.
                    state_d = ONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ZERO;
                    tick_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
        // Debounced level follows the state the FSM is about to occupy so the
        // output register changes on the same edge as the state register.
        level_d = (state_d == ONE) || (state_d == WAIT0);
    end

    // State, counter and registered outputs; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    assign db_level = level_q;
    assign db_tick  = tick_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed testbench for debounce_fsm at STABLE_CYCLES=4 with a 10 ns clock.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// A behavioural dual edge detector on db_level stands in for the downstream
// consumer of the debounced level.
module tb_debounce_fsm;

    logic clk = 1'b0;
    logic rst_n;
    logic sw;
    logic db_level;
    logic db_tick;

    int checks   = 0;
    int errors   = 0;
    int tick_cnt = 0;
    int edg_cnt  = 0;
    logic lvl_prev = 1'b0;
    logic edg;

    debounce_fsm #(.STABLE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 ns after each, and feed the
    // downstream edge detector model plus the tick counter.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (db_tick === 1'b1) tick_cnt++;
            edg = db_level ^ lvl_prev;
            if (edg === 1'b1) edg_cnt++;
            lvl_prev = db_level;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 1'b0;
        run(2);
        chk("reset_level", db_level, 0);
        chk("reset_tick", db_tick, 0);
        rst_n = 1'b1;
        run(4);
        chk("idle_level", db_level, 0);
        chk("idle_ticks", tick_cnt, 0);

        // Clean rise: first sampled at edge k, level changes after k+6.
        tick_cnt = 0; edg_cnt = 0;
        sw = 1'b1;
        run(6);
        chk("rise_before", db_level, 0);
        chk("rise_before_tick", db_tick, 0);
        run(1);
        chk("rise_level", db_level, 1);
        chk("rise_tick", db_tick, 1);
        run(1);
        chk("rise_tick_one_cycle", db_tick, 0);
        chk("rise_level_hold", db_level, 1);
        run(6);
        chk("rise_tick_count", tick_cnt, 1);
        chk("rise_edg_count", edg_cnt, 1);

        // Clean fall back to zero.
        tick_cnt = 0; edg_cnt = 0;
        sw = 1'b0;
        run(6);
        chk("fall_before", db_level, 1);
        run(1);
        chk("fall_level", db_level, 0);
        chk("fall_tick", db_tick, 1);
        run(4);
        chk("fall_tick_count", tick_cnt, 1);
        chk("fall_edg_count", edg_cnt, 1);

        // Exactly STABLE_CYCLES high samples: rejected.
        tick_cnt = 0; edg_cnt = 0;
        sw = 1'b1;
        run(4);
        sw = 1'b0;
        run(10);
        chk("glitch_level", db_level, 0);
        chk("glitch_ticks", tick_cnt, 0);
        chk("glitch_edg", edg_cnt, 0);

        // STABLE_CYCLES+1 high samples: accepted, then released.
        tick_cnt = 0; edg_cnt = 0;
        sw = 1'b1;
        run(5);
        sw = 1'b0;
        run(1);
        chk("minp_before", db_level, 0);
        run(1);
        chk("minp_rise", db_level, 1);
        chk("minp_rise_tick", db_tick, 1);
        run(4);
        chk("minp_hold", db_level, 1);
        run(1);
        chk("minp_fall", db_level, 0);
        chk("minp_fall_tick", db_tick, 1);
        run(5);
        chk("minp_tick_count", tick_cnt, 2);
        chk("minp_edg_count", edg_cnt, 2);

        // Bounce 1,0,1,1,0 then hold 1: one rise timed from the final 0->1.
        tick_cnt = 0; edg_cnt = 0;
        sw = 1'b1; run(1);
        sw = 1'b0; run(1);
        sw = 1'b1; run(1);
        sw = 1'b1; run(1);
        sw = 1'b0; run(1);
        sw = 1'b1;
        run(6);
        chk("bounce_before", db_level, 0);
        chk("bounce_no_early_tick", tick_cnt, 0);
        run(1);
        chk("bounce_rise", db_level, 1);
        chk("bounce_tick", db_tick, 1);
        run(6);
        chk("bounce_tick_count", tick_cnt, 1);
        chk("bounce_edg_count", edg_cnt, 1);

        // Reset while high: level drops with no tick.
        tick_cnt = 0; edg_cnt = 0;
        rst_n = 1'b0;
        run(1);
        chk("rst_one_level", db_level, 0);
        chk("rst_one_tick", db_tick, 0);
        rst_n = 1'b1;
        sw = 1'b0;
        run(10);
        chk("rst_one_after_level", db_level, 0);
        chk("rst_one_ticks", tick_cnt, 0);

        // Reset mid-qualification (WAIT1, cnt=2), then requalify.
        tick_cnt = 0; edg_cnt = 0;
        sw = 1'b1;
        run(5);
        rst_n = 1'b0;
        run(1);
        chk("rst_mid_level", db_level, 0);
        chk("rst_mid_tick", db_tick, 0);
        rst_n = 1'b1;
        run(6);
        chk("rst_mid_before", db_level, 0);
        chk("rst_mid_no_tick", tick_cnt, 0);
        run(1);
        chk("rst_mid_rise", db_level, 1);
        chk("rst_mid_rise_tick", db_tick, 1);
        run(5);
        chk("rst_mid_tick_count", tick_cnt, 1);
        chk("rst_mid_edg_count", edg_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
